clock_enable_gen: RTL
=====================

Name: clock_enable_gen

Overview:
- Parametrised successor to the PLL wrapper level of the clock tree.
- Runs entirely on one PLL output clock (e.g. mem_clk).
- Generates NUM_CH programmable, glitch-free clock-enable strobes, so slow domains (cpu/core/model loader) become enable-qualified logic on one clock.
- Qualifies the raw PLL lock with a 2-flop synchroniser and stability filter, then releases per-channel resets in a staggered sequence.

Parameters:
- NUM_CH, 4: number of enable/reset channels (1..16).
- DIV_W, 8: width of each channel's divide field; ratio = div+1 (1..256).
- LOCK_FILT, 16: consecutive synchronised-high lock cycles required before reset release.
- RST_STAGGER, 8: cycles between successive channel reset releases (>=1).
- DIV_RESET, 0: divide value loaded into every channel at reset.

Ports:
- clk  in  1  single block clock.
- resetn  in  1  asynchronous active-low reset.
- pll_lock_i  in  1  raw PLL lock, asynchronous to clk.
- div_i  in  NUM_CH*DIV_W  new divide values; channel k at bits [k*DIV_W +: DIV_W].
- div_load_i  in  1  one-cycle pulse; captures div_i into per-channel shadow registers.
- ch_en_i  in  NUM_CH  per-channel run enable.
- ce_o  out  NUM_CH  clock-enable strobes.
- rst_n_o  out  NUM_CH  per-channel synchronous active-low resets.
- locked_o  out  1  high in RUN state only.
- busy_o  out  NUM_CH  shadow divide value pending, not yet applied.

Behaviour:
- Reset (resetn low, async): FSM=WAIT_LOCK; ce_o=0, rst_n_o=0, locked_o=0, busy_o=0; div and shadow registers=DIV_RESET; all counters=0; sync flops=0.
- Lock synchroniser: 2 flops; lock_s lags pll_lock_i by 2 cycles. All FSM decisions use lock_s only.
- FSM states:
  - WAIT_LOCK: lock_s=1 -> FILTER, with the filter counter cleared.
  - FILTER: counter increments while lock_s=1. When count reaches LOCK_FILT-1 with lock_s=1 -> RELEASE, with the stagger counter and channel index cleared.
  - RELEASE: stagger counter increments. When it equals RST_STAGGER-1, rst_n_o[idx] goes 1 on the next edge, idx increments and the counter clears. Releasing idx=NUM_CH-1 -> RUN.
  - RUN: locked_o=1; dividers active.
- Lock loss: lock_s=0 in FILTER, RELEASE or RUN -> WAIT_LOCK on the next edge. Same edge: rst_n_o=0 (all), ce_o=0, locked_o=0, divider counters=0. div and shadow registers are retained.
- Divider, channel k:
  - Active only when state=RUN and ch_en_i[k]=1; otherwise counter=0 and ce_o[k]=0.
  - Counter runs 0..div[k]; ce_o[k] is registered and high for exactly the one cycle after counter==div[k]. Period = div[k]+1 cycles.
  - div[k]=0: ce_o[k] constantly high while active.
  - First ce_o[k] occurs div[k]+1 cycles after activation.
- Divide update:
  - div_load_i captures all channels into shadow registers and sets busy_o=all-ones.
  - An active channel applies its shadow at its next wrap (counter==div[k]): div[k]<=shadow, counter<=0, busy_o[k]<=0. This avoids a short period.
  - An inactive channel applies its shadow on the next cycle.
  - div_load_i on the same cycle as a wrap: the old shadow is discarded, the new value is captured and applied at the following wrap.
  - A second div_load_i while busy overwrites the shadow.
- ch_en_i deassert mid-period: counter clears, ce_o[k]=0 next cycle; re-enable restarts from 0.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package clock_enable_gen_pkg:
  - FSM state enum: WAIT_LOCK, FILTER, RELEASE, RUN.
  - Width constants: FILT_W=$clog2(LOCK_FILT), STG_W=$clog2(RST_STAGGER), IDX_W=$clog2(NUM_CH).
- One sub-module clk_div_ch: per-channel counter, shadow register, busy flag and ce register; instantiated NUM_CH times under a generate loop.
- FSM, synchroniser and reset sequencer stay in the top module.

Test Plan:
- Power-up (defaults): resetn rises, pll_lock_i=1 at cycle 0.
  - lock_s high at cycle 2; RELEASE entered at cycle 18.
  - rst_n_o[0..3] rise at cycles 26, 34, 42, 50; locked_o=1 from cycle 50.
- Filter glitch: pll_lock_i high 10 cycles, low 1, then high.
  - Returns to WAIT_LOCK; full 16-cycle filter restarts; no rst_n_o rises early.
- Divide ratios: in RUN with div={0,1,3,255}, all ch_en_i=1.
  - ce_o[0] constant 1; ce_o[1] period 2; ce_o[2] period 4; ce_o[3] period 256, each pulse 1 cycle.
- Glitch-free update: ch2 div=3, div_load_i with div=1 at counter=1.
  - Current period completes at 4 cycles, then period 2; busy_o[2] clears at the wrap.
- Lock loss in RUN: pll_lock_i drops.
  - 3 cycles later all rst_n_o=0, ce_o=0, locked_o=0.
  - Relock repeats the power-up sequence; divide values are preserved.
- Async reset mid-RELEASE (after rst_n_o[1] released): resetn low.
  - All outputs 0 immediately, without a clock edge; div values back to DIV_RESET.

Source files
------------

// File: rtl/clock_enable_gen_pkg.sv
// Shared types and helpers for the clock-enable generator.
// Counter widths depend on the top-level parameters, so they are derived there via cnt_w().
package clock_enable_gen_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } ceg_state_e;

    // Counter width for a modulus n; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One clock-enable channel: programmable divider with a shadowed divide value
// that is only applied at a period boundary (or immediately while idle).
module clk_div_ch
    import clock_enable_gen_pkg::*;
#(
    parameter int DIV_W     = 8,
    parameter int DIV_RESET = 0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             active,
    input  logic             load,
    input  logic [DIV_W-1:0] div_new,
    output logic             ce,
    output logic             busy
);

    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] shadow_r;
    logic [DIV_W-1:0] cnt_r;
    logic             ce_r;
    logic             busy_r;
    logic             wrap_s;
    logic             apply_s;

    assign wrap_s  = (cnt_r == div_r);
    // A load on the applying cycle wins: the fresh value waits for the next boundary.
    assign apply_s = busy_r && !load && (!active || wrap_s);

    // Divider counter, strobe, shadow capture and deferred divide update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_r    <= DIV_W'(DIV_RESET);
            shadow_r <= DIV_W'(DIV_RESET);
            cnt_r    <= {DIV_W{1'b0}};
            ce_r     <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            if (active) begin
                if (wrap_s) begin
                    cnt_r <= {DIV_W{1'b0}};
                    ce_r  <= 1'b1;
                end else begin
                    cnt_r <= cnt_r + DIV_W'(1'b1);
                    ce_r  <= 1'b0;
                end
            end else begin
                cnt_r <= {DIV_W{1'b0}};
                ce_r  <= 1'b0;
            end

            if (apply_s) begin
                div_r <= shadow_r;
            end else begin
                div_r <= div_r;
            end

            if (load) begin
                shadow_r <= div_new;
                busy_r   <= 1'b1;
            end else if (apply_s) begin
                busy_r   <= 1'b0;
            end else begin
                busy_r   <= busy_r;
            end
        end
    end

    assign ce   = ce_r;
    assign busy = busy_r;

endmodule

// File: rtl/clock_enable_gen.sv
// Single-clock enable generator: lock qualification, staggered channel reset
// release and NUM_CH glitch-free programmable clock-enable strobes.
module clock_enable_gen
    import clock_enable_gen_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int LOCK_FILT   = 16,
    parameter int RST_STAGGER = 8,
    parameter int DIV_RESET   = 0
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    pll_lock_i,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
    input  logic                    div_load_i,
    input  logic [NUM_CH-1:0]       ch_en_i,
    output logic [NUM_CH-1:0]       ce_o,
    output logic [NUM_CH-1:0]       rst_n_o,
    output logic                    locked_o,
    output logic [NUM_CH-1:0]       busy_o
);

    localparam int FILT_W = cnt_w(LOCK_FILT);
    localparam int STG_W  = cnt_w(RST_STAGGER);
    localparam int IDX_W  = cnt_w(NUM_CH);

    // The WAIT_LOCK cycle that first sees lock_s already counts as one qualified
    // cycle, so FILTER leaves after LOCK_FILT-1 further high cycles.
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'((LOCK_FILT > 1) ? (LOCK_FILT - 2) : 0);
    localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(RST_STAGGER - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CH - 1);

    logic              lock_meta_r;
    logic              lock_sync_r;
    ceg_state_e        state_r, state_s;
    logic [FILT_W-1:0] filt_cnt_r, filt_cnt_s;
    logic [STG_W-1:0]  stg_cnt_r, stg_cnt_s;
    logic [IDX_W-1:0]  idx_r, idx_s;
    logic [NUM_CH-1:0] rst_n_r, rst_n_s;
    logic              locked_r, locked_s;
    logic              run_s;

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= pll_lock_i;
            lock_sync_r <= lock_meta_r;
        end
    end

    // Sequencer state, counters and registered reset/lock outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= WAIT_LOCK;
            filt_cnt_r <= {FILT_W{1'b0}};
            stg_cnt_r  <= {STG_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            rst_n_r    <= {NUM_CH{1'b0}};
            locked_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            filt_cnt_r <= filt_cnt_s;
            stg_cnt_r  <= stg_cnt_s;
            idx_r      <= idx_s;
            rst_n_r    <= rst_n_s;
            locked_r   <= locked_s;
        end
    end

    // Next-state logic: lock filtering, staggered release, lock-loss fallback.
    always_comb begin
        state_s    = state_r;
        filt_cnt_s = filt_cnt_r;
        stg_cnt_s  = stg_cnt_r;
        idx_s      = idx_r;
        rst_n_s    = rst_n_r;
        locked_s   = 1'b0;
        case (state_r)
            WAIT_LOCK: begin
                rst_n_s = {NUM_CH{1'b0}};
                if (lock_sync_r) begin
                    state_s    = FILTER;
                    filt_cnt_s = {FILT_W{1'b0}};
                end else begin
                    state_s    = WAIT_LOCK;
                end
            end
            FILTER: begin
                if (!lock_sync_r) begin
                    state_s = WAIT_LOCK;
                    rst_n_s = {NUM_CH{1'b0}};
                end else if (filt_cnt_r == FILT_LAST) begin
                    state_s   = RELEASE;
                    stg_cnt_s = {STG_W{1'b0}};
                    idx_s     = {IDX_W{1'b0}};
                end else begin
                    filt_cnt_s = filt_cnt_r + FILT_W'(1'b1);
                end
            end
            RELEASE: begin
                if (!lock_sync_r) begin
                    state_s = WAIT_LOCK;
                    rst_n_s = {NUM_CH{1'b0}};
                end else if (stg_cnt_r == STG_LAST) begin
                    rst_n_s[idx_r] = 1'b1;
                    stg_cnt_s      = {STG_W{1'b0}};
                    if (idx_r == IDX_LAST) begin
                        state_s  = RUN;
                        locked_s = 1'b1;
                    end else begin
                        idx_s    = idx_r + IDX_W'(1'b1);
                    end
                end else begin
                    stg_cnt_s = stg_cnt_r + STG_W'(1'b1);
                end
            end
            RUN: begin
                if (!lock_sync_r) begin
                    state_s = WAIT_LOCK;
                    rst_n_s = {NUM_CH{1'b0}};
                end else begin
                    locked_s = 1'b1;
                end
            end
            default: begin
                state_s = WAIT_LOCK;
                rst_n_s = {NUM_CH{1'b0}};
            end
        endcase
    end

    // Dividers stop on the very edge that lock_s drops, together with the resets.
    assign run_s = (state_r == RUN) && lock_sync_r;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_div_ch #(
            .DIV_W     (DIV_W),
            .DIV_RESET (DIV_RESET)
        ) u_ch (
            .clk     (clk),
            .resetn  (resetn),
            .active  (run_s & ch_en_i[k]),
            .load    (div_load_i),
            .div_new (div_i[k*DIV_W +: DIV_W]),
            .ce      (ce_o[k]),
            .busy    (busy_o[k])
        );
    end

    assign rst_n_o  = rst_n_r;
    assign locked_o = locked_r;

endmodule
